// File: rtl/edu_data_path_v2.sv
`default_nettype none
// ============================================================================
// Module   : edu_data_path_v2
// Brief    : EDULENT gen-2 datapath driven by explicit control-unit commands,
//            with a req/ack memory port.
//            Optional macro DP_STACK_GUARD_EN enables the stack over/underflow guard.
// Revision : 1.0  initial release
// ============================================================================
module edu_data_path_v2 #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int PC_INIT = 0,
    parameter int SP_INIT = 0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_valid,
    input  logic [3:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_sel,
    input  logic [1:0]        i_cond,
    input  logic              i_alu_calculate,
    input  logic [3:0]        i_alu_op,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_reset_ir,
    input  logic [DATA_W-1:0] i_in,
    output logic [DATA_W-1:0] o_out,
    output logic [DATA_W-1:0] o_ir,
    output logic [3:0]        o_flags,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_stack_fault
);

    localparam int EXT_W = DATA_W + 1;
    localparam int MSB   = DATA_W - 1;

    localparam logic [3:0] c_CMD_MA_PC  = 4'h1;
    localparam logic [3:0] c_CMD_READ   = 4'h2;
    localparam logic [3:0] c_CMD_IR_MD  = 4'h3;
    localparam logic [3:0] c_CMD_MA_MD  = 4'h4;
    localparam logic [3:0] c_CMD_RG_MD  = 4'h5;
    localparam logic [3:0] c_CMD_MA_AP  = 4'h6;
    localparam logic [3:0] c_CMD_MA_SP  = 4'h7;
    localparam logic [3:0] c_CMD_MD_RG  = 4'h8;
    localparam logic [3:0] c_CMD_WRITE  = 4'h9;
    localparam logic [3:0] c_CMD_RG_R   = 4'hA;
    localparam logic [3:0] c_CMD_BRANCH = 4'hB;
    localparam logic [3:0] c_CMD_A_IN   = 4'hC;
    localparam logic [3:0] c_CMD_OUT_A  = 4'hD;
    localparam logic [3:0] c_CMD_PC_AP  = 4'hE;
    localparam logic [3:0] c_CMD_MD_PC  = 4'hF;

    localparam logic [3:0] c_ALU_ADD  = 4'h0;
    localparam logic [3:0] c_ALU_SUB  = 4'h1;
    localparam logic [3:0] c_ALU_NOT  = 4'h2;
    localparam logic [3:0] c_ALU_OR   = 4'h3;
    localparam logic [3:0] c_ALU_AND  = 4'h4;
    localparam logic [3:0] c_ALU_XOR  = 4'h5;
    localparam logic [3:0] c_ALU_PASS = 4'h6;
    localparam logic [3:0] c_ALU_SHL  = 4'h7;
    localparam logic [3:0] c_ALU_SHR  = 4'h8;
    localparam logic [3:0] c_ALU_ADC  = 4'h9;
    localparam logic [3:0] c_ALU_SBB  = 4'hA;

    localparam int c_FLAG_Z = 0;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d, ma_q, ma_d;
    logic [DATA_W-1:0] md_q, md_d, ir_q, ir_d, a_q, a_d, ap_q, ap_d;
    logic [DATA_W-1:0] r_q, r_d, in_q, in_d, out_q, out_d;
    logic [3:0]        flags_q, flags_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
`ifdef DP_STACK_GUARD_EN
    logic              fault_q, fault_d;
`endif

    logic              w_accept;
    logic              w_cond_true;
    logic              w_alu_cin;
    logic [EXT_W-1:0]  w_alu_add, w_alu_sub;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c, w_alu_v;

    assign w_accept = i_cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        w_cond_true = 1'b1;
        case (i_cond)
            2'd1:    w_cond_true = flags_q[c_FLAG_Z];
            2'd2:    w_cond_true = flags_q[c_FLAG_C];
            2'd3:    w_cond_true = flags_q[c_FLAG_N];
            default: w_cond_true = 1'b1;
        endcase
    end

    // Arithmetic on DATA_W+1 bits: the extra MSB is carry-out for add, borrow for subtract.
    always_comb begin
        w_alu_cin = ((i_alu_op == c_ALU_ADC) || (i_alu_op == c_ALU_SBB)) ? flags_q[c_FLAG_C] : 1'b0;
        w_alu_add = {1'b0, a_q} + {1'b0, md_q} + EXT_W'(w_alu_cin);
        w_alu_sub = {1'b0, a_q} - {1'b0, md_q} - EXT_W'(w_alu_cin);
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (i_alu_op)
            c_ALU_ADD, c_ALU_ADC: begin
                w_alu_res = w_alu_add[DATA_W-1:0];
                w_alu_c   = w_alu_add[DATA_W];
                w_alu_v   = (a_q[MSB] == md_q[MSB]) && (w_alu_add[MSB] != a_q[MSB]);
            end
            c_ALU_SUB, c_ALU_SBB: begin
                w_alu_res = w_alu_sub[DATA_W-1:0];
                w_alu_c   = w_alu_sub[DATA_W];
                w_alu_v   = (a_q[MSB] != md_q[MSB]) && (w_alu_sub[MSB] != a_q[MSB]);
            end
            c_ALU_NOT:  w_alu_res = ~a_q;
            c_ALU_OR:   w_alu_res = a_q | md_q;
            c_ALU_AND:  w_alu_res = a_q & md_q;
            c_ALU_XOR:  w_alu_res = a_q ^ md_q;
            c_ALU_PASS: w_alu_res = a_q;
            c_ALU_SHL: begin
                w_alu_res = a_q << 1;
                w_alu_c   = a_q[MSB];
            end
            c_ALU_SHR: begin
                w_alu_res = a_q >> 1;
                w_alu_c   = a_q[0];
            end
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        ma_d      = ma_q;
        md_d      = md_q;
        ir_d      = ir_q;
        a_d       = a_q;
        ap_d      = ap_q;
        r_d       = r_q;
        in_d      = i_in;
        out_d     = out_q;
        flags_d   = flags_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
`ifdef DP_STACK_GUARD_EN
        fault_d   = fault_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_accept && (i_cmd == c_CMD_READ)) begin
                    state_d   = ST_RD_WAIT;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                end else if (w_accept && (i_cmd == c_CMD_WRITE)) begin
                    state_d   = ST_WR_WAIT;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (i_mem_ack) begin
                    md_d      = i_mem_rdata;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_WR_WAIT: begin
                if (i_mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        // Increment first so a PC load from a command below takes precedence.
        if (i_inc_pc) pc_d = pc_q + ADDR_W'(1);

        if (w_accept) begin
            case (i_cmd)
                c_CMD_MA_PC:  ma_d = pc_q;
                c_CMD_IR_MD:  ir_d = md_q;
                c_CMD_MA_MD:  ma_d = ADDR_W'(md_q);
                c_CMD_RG_MD:  if (i_sel) ap_d = md_q; else a_d = md_q;
                c_CMD_MA_AP:  ma_d = ADDR_W'(ap_q);
                c_CMD_MA_SP:  ma_d = sp_q;
                c_CMD_MD_RG:  md_d = i_sel ? ap_q : a_q;
                c_CMD_RG_R:   if (i_sel) ap_d = r_q; else a_d = r_q;
                c_CMD_BRANCH: if (w_cond_true) pc_d = ADDR_W'(md_q);
                c_CMD_A_IN:   a_d = in_q;
                c_CMD_OUT_A:  out_d = a_q;
                c_CMD_PC_AP:  pc_d = ADDR_W'(ap_q);
                c_CMD_MD_PC:  md_d = DATA_W'(pc_q);
                default: ;
            endcase
        end

        if (i_reset_ir) ir_d = '0;

        if (i_alu_calculate) begin
            r_d     = w_alu_res;
            flags_d = {w_alu_res[MSB], w_alu_v, w_alu_c, (w_alu_res == '0)};
        end

`ifdef DP_STACK_GUARD_EN
        if (i_inc_dec_sp == 2'b01) begin
            if (&sp_q) fault_d = 1'b1;
            else       sp_d    = sp_q + ADDR_W'(1);
        end else if (i_inc_dec_sp == 2'b10) begin
            if (sp_q == '0) fault_d = 1'b1;
            else            sp_d    = sp_q - ADDR_W'(1);
        end
`else
        if (i_inc_dec_sp == 2'b01)      sp_d = sp_q + ADDR_W'(1);
        else if (i_inc_dec_sp == 2'b10) sp_d = sp_q - ADDR_W'(1);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            pc_q      <= ADDR_W'(PC_INIT);
            sp_q      <= ADDR_W'(SP_INIT);
            ma_q      <= '0;
            md_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            ap_q      <= '0;
            r_q       <= '0;
            in_q      <= '0;
            out_q     <= '0;
            flags_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef DP_STACK_GUARD_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            ma_q      <= ma_d;
            md_q      <= md_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            ap_q      <= ap_d;
            r_q       <= r_d;
            in_q      <= in_d;
            out_q     <= out_d;
            flags_q   <= flags_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
`ifdef DP_STACK_GUARD_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_out       = out_q;
    assign o_ir        = ir_q;
    assign o_flags     = flags_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = ma_q;
    assign o_mem_wdata = (mem_req_q && mem_we_q) ? md_q : '0;
`ifdef DP_STACK_GUARD_EN
    assign o_stack_fault = fault_q;
`else
    assign o_stack_fault = 1'b0;
`endif

endmodule
`default_nettype wire
